// File: rtl/arbitro_periferico_if.sv
// Bundle of the two CPU-side send/ack ports, the peripheral port and the arbiter status.
// No logic; the arbiter drives its outputs from registered state only.
// Backpressure is the 4-phase send/ack handshake on every port.
interface arbitro_periferico_if;
  logic       cpu0_send;
  logic [3:0] cpu0_dados;
  logic       cpu0_ack;
  logic       cpu1_send;
  logic [3:0] cpu1_dados;
  logic       cpu1_ack;
  logic       per_send;
  logic [3:0] per_dados;
  logic       per_ack;
  logic [1:0] arb_grant;
  logic       arb_erro;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  // arbiter side
  modport slave (
    input  cpu0_send, cpu0_dados, cpu1_send, cpu1_dados, per_ack,
    output cpu0_ack, cpu1_ack, per_send, per_dados, arb_grant, arb_erro, cnt0, cnt1
  );

  // environment side (CPUs + peripheral + observer)
  modport master (
    output cpu0_send, cpu0_dados, cpu1_send, cpu1_dados, per_ack,
    input  cpu0_ack, cpu1_ack, per_send, per_dados, arb_grant, arb_erro, cnt0, cnt1
  );
endinterface

// File: rtl/arbitro_periferico.sv
// Round-robin arbiter giving two CPUs shared access to one send/ack peripheral.
// Latency: grant and per_send one cycle after request; cpu ack one cycle after per_ack.
// Backpressure: the loser waits in IDLE; a silent peripheral is aborted after TIMEOUT cycles.
module arbitro_periferico #(
  parameter int TIMEOUT = 8
) (
  input logic            arb_clk,
  input logic            arb_rst,
  arbitro_periferico_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, ACK, ERR} state_t;

  state_t     state;
  state_t     next_state;
  logic       dono;      // current owner: 0 = master 0, 1 = master 1
  logic       ultimo;    // last master served (completed or aborted)
  logic [3:0] dado;      // data captured at grant, held for the whole transfer
  logic [7:0] tmo_cnt;
  logic [7:0] cnt0_q;
  logic [7:0] cnt1_q;

  logic req_any;
  logic vencedor;
  logic dono_send;
  logic tmo_hit;
  logic ack_exit;

  assign req_any   = bus.cpu0_send | bus.cpu1_send;
  // On a tie the master that was not served last wins; otherwise the sole requester.
  assign vencedor  = (bus.cpu0_send & bus.cpu1_send) ? ~ultimo : bus.cpu1_send;
  assign dono_send = dono ? bus.cpu1_send : bus.cpu0_send;
  // Counter holds the number of ack-less SEND cycles already seen; this is the TIMEOUT-th.
  assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT - 1));
  // Handshake closes only once both the owner and the peripheral have released.
  assign ack_exit  = ~dono_send & ~bus.per_ack;

  // State register
  always_ff @(posedge arb_clk) begin
    if (arb_rst) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_any) next_state = SEND;
      SEND:    if (bus.per_ack) next_state = ACK;
               else if (tmo_hit) next_state = ERR;
      ACK:     if (ack_exit) next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Owner, data capture, timeout counter, round-robin pointer and transfer counters
  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      dono    <= 1'b0;
      ultimo  <= 1'b1;
      dado    <= 4'h0;
      tmo_cnt <= 8'd0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            dono    <= vencedor;
            dado    <= vencedor ? bus.cpu1_dados : bus.cpu0_dados;
            tmo_cnt <= 8'd0;
          end
        end
        SEND: begin
          if (!bus.per_ack) tmo_cnt <= tmo_cnt + 8'd1;
        end
        ACK: begin
          if (ack_exit) begin
            ultimo <= dono;
            if (dono) cnt1_q <= cnt1_q + 8'd1;
            else      cnt0_q <= cnt0_q + 8'd1;
          end
        end
        ERR: begin
          // Aborted master loses priority but its counter is not credited.
          ultimo <= dono;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.per_send  = (state == SEND);
    bus.per_dados = ((state == SEND) || (state == ACK)) ? dado : 4'h0;
    bus.cpu0_ack  = (state == ACK) && !dono;
    bus.cpu1_ack  = (state == ACK) && dono;
    bus.arb_grant = (state == IDLE) ? 2'b00 : {dono, ~dono};
    bus.arb_erro  = (state == ERR);
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_arbitro_periferico.sv
// Scoreboard bench for arbitro_periferico: expected (master, data) pushed at request,
// popped when the peripheral sees the transfer; counters tracked by a small model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_arbitro_periferico;

  localparam int TMO = 8;

  typedef struct packed {
    logic       m;
    logic [3:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_r [2];
  logic [3:0] dados_r [2];
  logic       per_ack_r;

  exp_t       sb [$];
  logic [7:0] exp_cnt [2];
  int         n_vec = 0;
  int         n_err = 0;

  arbitro_periferico_if bus ();

  arbitro_periferico #(.TIMEOUT(TMO)) dut (
    .arb_clk (clk),
    .arb_rst (rst),
    .bus     (bus)
  );

  assign bus.cpu0_send  = send_r[0];
  assign bus.cpu1_send  = send_r[1];
  assign bus.cpu0_dados = dados_r[0];
  assign bus.cpu1_dados = dados_r[1];
  assign bus.per_ack    = per_ack_r;

  wire [1:0] acks = {bus.cpu1_ack, bus.cpu0_ack};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic m, input logic [3:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt[0] = 8'd0;
    exp_cnt[1] = 8'd0;
  endtask

  // DUT has just entered SEND. Peripheral acks after dly cycles, then the
  // handshake is closed; keep re-raises the owner's request afterwards.
  task automatic serve(input int dly, input bit keep);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("grant", bus.arb_grant, 32'd1 << e.m);
    chk("per_send_up", bus.per_send, 1);
    chk("per_dados", bus.per_dados, e.d);
    chk("ack_idle_in_send", acks, 0);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("hold_send", bus.per_send, 1);
      chk("hold_dados", bus.per_dados, e.d);
    end
    per_ack_r = 1'b1;
    tick();
    chk("cpu_ack_up", acks, 32'd1 << e.m);
    chk("per_send_down", bus.per_send, 0);
    // Owner releases but peripheral still holds ack: handshake must stay open.
    send_r[e.m] = 1'b0;
    tick();
    chk("ack_held", acks, 32'd1 << e.m);
    per_ack_r = 1'b0;
    tick();
    exp_cnt[e.m] = exp_cnt[e.m] + 8'd1;
    chk("ack_down", acks, 0);
    chk("grant_idle", bus.arb_grant, 0);
    chk("cnt0", bus.cnt0, exp_cnt[0]);
    chk("cnt1", bus.cnt1, exp_cnt[1]);
    if (keep) send_r[e.m] = 1'b1;
  endtask

  initial begin
    exp_t e;
    int   ns, ne, na;
    send_r[0] = 1'b0; send_r[1] = 1'b0;
    dados_r[0] = 4'h0; dados_r[1] = 4'h0;
    per_ack_r = 1'b0;
    apply_reset();

    // Reset state
    chk("rst_grant", bus.arb_grant, 0);
    chk("rst_per_send", bus.per_send, 0);
    chk("rst_per_dados", bus.per_dados, 0);
    chk("rst_acks", acks, 0);
    chk("rst_erro", bus.arb_erro, 0);
    chk("rst_cnt0", bus.cnt0, 0);
    chk("rst_cnt1", bus.cnt1, 0);

    // Simultaneous requests after reset: 0,1,0,1
    dados_r[0] = 4'h3; dados_r[1] = 4'hC;
    send_r[0] = 1'b1; send_r[1] = 1'b1;
    push(1'b0, 4'h3); push(1'b1, 4'hC); push(1'b0, 4'h3); push(1'b1, 4'hC);
    for (int i = 0; i < 4; i++) begin
      tick();
      serve(1, i < 2);
    end

    // Single transfer, peripheral acks 2 cycles after per_send
    dados_r[0] = 4'hA; send_r[0] = 1'b1;
    push(1'b0, 4'hA);
    tick();
    chk("grant_latency", bus.per_send, 1);
    serve(2, 1'b0);

    // Timeout on master 1, then master 0 wins the tie
    dados_r[1] = 4'h7; send_r[1] = 1'b1;
    push(1'b1, 4'h7);
    tick();
    e = sb.pop_front();
    chk("tmo_grant", bus.arb_grant, 32'd1 << e.m);
    chk("tmo_dados", bus.per_dados, e.d);
    dados_r[0] = 4'h6; send_r[0] = 1'b1;
    push(1'b0, 4'h6);
    ns = int'(bus.per_send); ne = 0; na = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      ns += int'(bus.per_send);
      ne += int'(bus.arb_erro);
      na += int'(bus.cpu1_ack);
      if (i == 7) chk("erro_at_timeout", bus.arb_erro, 1);
    end
    chk("tmo_send_cycles", ns, TMO);
    chk("tmo_erro_pulses", ne, 1);
    chk("tmo_no_ack1", na, 0);
    chk("tmo_cnt1", bus.cnt1, exp_cnt[1]);
    chk("tmo_grant_idle", bus.arb_grant, 0);
    tick();
    serve(1, 1'b0);
    send_r[1] = 1'b0;

    // Data stability while in SEND
    dados_r[0] = 4'h5; send_r[0] = 1'b1;
    push(1'b0, 4'h5);
    tick();
    dados_r[0] = 4'h9;
    serve(3, 1'b0);

    // Reset during ACK
    dados_r[0] = 4'h2; send_r[0] = 1'b1;
    tick();
    chk("mid_grant", bus.arb_grant, 1);
    per_ack_r = 1'b1;
    tick();
    chk("mid_in_ack", acks, 1);
    rst = 1'b1;
    dados_r[1] = 4'hD; send_r[1] = 1'b1;
    tick();
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0;
    chk("mid_grant_rst", bus.arb_grant, 0);
    chk("mid_per_send", bus.per_send, 0);
    chk("mid_per_dados", bus.per_dados, 0);
    chk("mid_acks", acks, 0);
    chk("mid_erro", bus.arb_erro, 0);
    chk("mid_cnt0", bus.cnt0, 0);
    chk("mid_cnt1", bus.cnt1, 0);
    rst = 1'b0;
    per_ack_r = 1'b0;
    push(1'b0, 4'h2); push(1'b1, 4'hD);
    tick();
    serve(0, 1'b0);
    tick();
    serve(0, 1'b0);

    // Counter wrap on master 1
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      dados_r[1] = 4'(i);
      send_r[1] = 1'b1;
      push(1'b1, 4'(i));
      tick();
      serve(0, 1'b0);
      if (i == 254) chk("cnt1_at_255", bus.cnt1, 255);
    end
    chk("wrap_cnt1", bus.cnt1, 0);
    chk("wrap_cnt0", bus.cnt0, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arbitro_periferico.md
# arbitro_periferico

Two-master arbiter sharing one peripheral send/ack port between two CPU-side requesters. Each CPU uses the 4-phase send/ack handshake (raise send with 4-bit dados, wait ack, drop send, wait ack low). The arbiter grants requests round-robin, forwards the granted CPU's data to the peripheral, and relays the peripheral ack back. It also applies an ack timeout and keeps per-master transfer counters. It sits between the CPU instances and the single PERIFERICO instance.

## Interface
- TIMEOUT, 8, number of SEND cycles without per_ack before abort; legal range 2..255.
- arb_clk  input  1  clock; all state updates on rising edge.
- arb_rst  input  1  reset, synchronous and active-high.
- cpu0_send  input  1  request/valid from master 0.
- cpu0_dados  input  4  data from master 0; sampled at grant.
- cpu0_ack  output  1  ack to master 0.
- cpu1_send  input  1  request/valid from master 1.
- cpu1_dados  input  4  data from master 1; sampled at grant.
- cpu1_ack  output  1  ack to master 1.
- per_send  output  1  send to peripheral.
- per_dados  output  4  data to peripheral.
- per_ack  input  1  ack from peripheral.
- arb_grant  output  2  one-hot owner: bit0 = master 0, bit1 = master 1; 00 when IDLE.
- arb_erro  output  1  one-cycle pulse on timeout abort.
- cnt0, cnt1  output  8 each  completed transfers per master; wrap 255→0.

## Operation
- FSM states: IDLE, SEND, ACK, ERR. All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- IDLE:
  - If any cpuN_send=1, select the winner: if both request, take the master not equal to `ultimo` (last-served pointer); otherwise take the sole requester.
  - Capture the winner's dados into the data register, set arb_grant, clear the timeout counter, go to SEND.
- SEND:
  - per_send=1; per_dados=captured value. The value is held stable even if cpuN_dados changes.
  - per_ack=1 → go to ACK.
  - Else increment the timeout counter. On the TIMEOUT-th consecutive cycle with per_ack=0, go to ERR.
- ACK:
  - per_send=0; granted cpuN_ack=1.
  - When granted cpuN_send=0 AND per_ack=0 → go to IDLE. On that transition: cpuN_ack=0, arb_grant=00, increment cntN, set ultimo=N.
- ERR (one cycle): per_send=0, no cpu ack, arb_erro=1, ultimo=N, cntN unchanged, then IDLE. The aborted master still holds send, so it is re-arbitrated from IDLE with lowered priority.
- The non-granted master's request is ignored until IDLE; its ack stays 0.
- In IDLE, per_dados=0000 and per_send=0.
- Reset values: state IDLE, ultimo=1 (master 0 wins the first tie), all acks 0, per_send 0, per_dados 0000, arb_grant 00, arb_erro 0, cnt0=cnt1=0, timeout counter 0.
- Reset asserted mid-transfer forces the reset values at the next edge; no ack or counter update for the interrupted transfer.

## Timing
- Request sampled in IDLE at edge k → per_send=1 and arb_grant valid after edge k (1-cycle grant latency).
- per_ack=1 sampled at edge m in SEND → cpuN_ack=1 and per_send=0 after edge m.
- A stale per_ack cannot complete a new transfer, because ACK requires per_ack=0 before IDLE.
- ACK exit at edge p → IDLE after p. The earliest next grant is at edge p+1 (at least 1 idle cycle between transfers).
- Timeout: SEND entered after edge k with per_ack held 0 → ERR after edge k+TIMEOUT, arb_erro high for exactly that cycle, IDLE after edge k+TIMEOUT+1.
- Counter wrap: cntN=255 plus one completion → 0.
- cpuN_send dropping during SEND does not abort the transfer; completion still requires the ACK exit condition.

## Test plan
- **Single transfer:** cpu0_send=1, dados=4'hA; peripheral acks 2 cycles after per_send → per_dados=A, cpu0_ack rises the cycle after per_ack, cnt0=1, arb_grant back to 00 after the handshake closes.
- **Simultaneous requests after reset:** dados0=3, dados1=C → master 0 served first (per_dados=3), then master 1 (per_dados=C); continuous requests alternate 0,1,0,1.
- **Timeout:** TIMEOUT=8, per_ack tied 0, cpu1 requests → per_send high exactly 8 cycles, arb_erro pulses once, cnt1 stays 0, no cpu1_ack; with cpu0 also requesting, master 0 is granted next.
- **Data stability:** cpu0_dados changes 5→9 during SEND → per_dados stays 5 until ACK.
- **Reset mid-transfer:** arb_rst=1 during ACK state → after the edge all outputs are at reset values, cnt unchanged at 0; next tie goes to master 0.
- **Wrap:** 256 completed master 1 transfers → cnt1 returns to 0; cnt0 unaffected.
